// File: rtl/ring_buffer_pkg.sv
// Shared defaults for the ring buffer slice: word width and depth used when
// the queue is instantiated without overrides.
package ring_buffer_pkg;

  localparam int RB_DEFAULT_WIDTH = 4;
  localparam int RB_DEFAULT_SIZE  = 8;

endpackage : ring_buffer_pkg

// File: rtl/ring_buffer_register.sv
// Generic WIDTH-bit register with load enable and asynchronous active-high
// reset to zero. Used for the queue's read and write pointers.
module ring_buffer_register #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Hold the stored value unless loaded; reset forces zero without a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule : ring_buffer_register

// File: rtl/ring_buffer.sv
// Synchronous circular FIFO with show-ahead read. Pointers carry one extra
// wrap bit so that full and empty are distinguishable with equal indices.
// Reset clears only the pointers; storage keeps whatever it held.
module ring_buffer
  import ring_buffer_pkg::*;
#(
  parameter int WIDTH = RB_DEFAULT_WIDTH,
  parameter int SIZE  = RB_DEFAULT_SIZE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_we,
  input  logic             i_re,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             write_ok;
  logic             read_ok;
  logic [WIDTH-1:0] mem [SIZE];

  // Flags, accept qualifiers and pointer increments are pure functions of
  // the current pointers. A write while full is still taken if a pop frees
  // the head slot in the same cycle; a pop while empty is never taken.
  always_comb begin
    o_empty     = (wr_ptr == rd_ptr);
    o_full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                  (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    write_ok    = i_we && (!o_full || i_re);
    read_ok     = i_re && !o_empty;
    wr_ptr_next = wr_ptr + PTR_W'(1);
    rd_ptr_next = rd_ptr + PTR_W'(1);
  end

  ring_buffer_register #(.WIDTH(PTR_W)) u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (write_ok),
    .i_d   (wr_ptr_next),
    .o_q   (wr_ptr)
  );

  ring_buffer_register #(.WIDTH(PTR_W)) u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (read_ok),
    .i_d   (rd_ptr_next),
    .o_q   (rd_ptr)
  );

  // Storage is deliberately left without reset; only accepted writes land.
  always_ff @(posedge i_clk) begin
    if (write_ok) begin
      mem[wr_ptr[IDX_W-1:0]] <= i_data;
    end
  end

  // Show-ahead head of queue; stale when empty.
  always_comb begin
    o_data = mem[rd_ptr[IDX_W-1:0]];
  end

endmodule : ring_buffer

// File: tb/tb_ring_buffer.sv
// Directed bench for ring_buffer (WIDTH=4, SIZE=8): table of vectors for
// fill/drain/overflow/underflow, plus hand sequences for wrap and reset.
module tb_ring_buffer;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_data;
  logic       i_we;
  logic       i_re;
  logic [3:0] o_data;
  logic       o_empty;
  logic       o_full;

  int checks;
  int failures;

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] data;
    logic       exp_empty;
    logic       exp_full;
    logic       chk_data;
    logic [3:0] exp_data;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] model[$];

  ring_buffer #(.WIDTH(4), .SIZE(8)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_we    (i_we),
    .i_re    (i_re),
    .o_data  (o_data),
    .o_empty (o_empty),
    .o_full  (o_full)
  );

  initial i_clk = 1'b0;
  always #20 i_clk = ~i_clk;

  task automatic addVec(input logic we, input logic re, input logic [3:0] data,
                        input logic e, input logic f, input logic cd,
                        input logic [3:0] d);
    vec_t v;
    v.we = we; v.re = re; v.data = data;
    v.exp_empty = e; v.exp_full = f; v.chk_data = cd; v.exp_data = d;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic e, input logic f,
                             input logic cd, input logic [3:0] d);
    checks++;
    if (o_empty !== e) begin
      failures++;
      $display("[TB] FAIL %s: o_empty got %b expected %b", name, o_empty, e);
    end
    checks++;
    if (o_full !== f) begin
      failures++;
      $display("[TB] FAIL %s: o_full got %b expected %b", name, o_full, f);
    end
    if (cd) begin
      checks++;
      if (o_data !== d) begin
        failures++;
        $display("[TB] FAIL %s: o_data got %h expected %h", name, o_data, d);
      end
    end
  endtask

  // Drive inputs mid-cycle, take one rising edge, then settle before checks.
  task automatic applyStimulus(input logic we, input logic re, input logic [3:0] data);
    i_we = we; i_re = re; i_data = data;
    @(posedge i_clk);
    #5;
  endtask

  initial begin
    i_rst = 1'b1; i_we = 1'b0; i_re = 1'b0; i_data = 4'h0;
    checks = 0; failures = 0;

    // Fill: first write shows ahead, eighth sets full, ninth (7) dropped.
    addVec(1, 0, 4'hF, 0, 0, 1, 4'hF);
    for (int k = 0; k < 7; k++)
      addVec(1, 0, 4'(k), 0, (k == 6), 1, 4'hF);
    addVec(1, 0, 4'h7, 0, 1, 1, 4'hF);
    // Drain: heads 0..6 after pops 1..7, empty after 8th, extra pops inert.
    for (int k = 0; k < 7; k++)
      addVec(0, 1, 4'h0, 0, 0, 1, 4'(k));
    addVec(0, 1, 4'h0, 1, 0, 0, 4'h0);
    addVec(0, 1, 4'h0, 1, 0, 0, 4'h0);
    addVec(0, 1, 4'h0, 1, 0, 0, 4'h0);
    // Read with write while empty: only the write happens.
    addVec(1, 1, 4'h9, 0, 0, 1, 4'h9);
    addVec(0, 1, 4'h0, 1, 0, 0, 4'h0);
    // Refill with 0..7.
    for (int k = 0; k < 8; k++)
      addVec(1, 0, 4'(k), 0, (k == 7), 1, 4'h0);
    // Full with simultaneous read/write of A: head moves to 1, stays full.
    addVec(1, 1, 4'hA, 0, 1, 1, 4'h1);
    // Pop through: heads 2..7, then A, then empty.
    for (int k = 2; k < 8; k++)
      addVec(0, 1, 4'h0, 0, 0, 1, 4'(k));
    addVec(0, 1, 4'h0, 0, 0, 1, 4'hA);
    addVec(0, 1, 4'h0, 1, 0, 0, 4'h0);

    // Reset state while held, and after release with idle inputs.
    #5;
    checkOutput("reset_held", 1, 0, 0, 4'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #5;
    checkOutput("reset_idle", 1, 0, 0, 4'h0);

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].we, vecs[n].re, vecs[n].data);
      checkOutput($sformatf("vec%0d", n), vecs[n].exp_empty, vecs[n].exp_full,
                  vecs[n].chk_data, vecs[n].exp_data);
    end

    // Mixed traffic: 20 writes, reads from the fourth cycle on; pointers
    // wrap at least twice. Expectations come from a queue model.
    for (int n = 0; n < 24; n++) begin
      logic       we, re, wa, ra;
      logic [3:0] d;
      we = (n < 20);
      re = (n >= 3);
      d  = 4'(n) ^ 4'h5;
      wa = we && (model.size() < 8 || re);
      ra = re && (model.size() > 0);
      if (ra) void'(model.pop_front());
      if (wa) model.push_back(d);
      applyStimulus(we, re, d);
      checkOutput($sformatf("wrap%0d", n), (model.size() == 0),
                  (model.size() == 8), (model.size() > 0),
                  (model.size() > 0) ? model[0] : 4'h0);
    end

    // Mid-operation reset pulse between edges discards contents at once.
    applyStimulus(1, 0, 4'h3);
    applyStimulus(1, 0, 4'h4);
    checkOutput("pre_pulse", 0, 0, 1, 4'h3);
    #5;
    i_rst = 1'b1;
    #1;
    checkOutput("pulse_high", 1, 0, 0, 4'h0);
    #4;
    i_rst = 1'b0;
    #1;
    checkOutput("pulse_low", 1, 0, 0, 4'h0);
    applyStimulus(1, 0, 4'hC);
    checkOutput("post_pulse", 0, 0, 1, 4'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_ring_buffer
